pipe_fetch_unit: RTL and testbench
==================================

Name: pipe_fetch_unit

Overview:
- IF stage of the 5-stage pipe. It owns the fetch PC, drives a req/ack instruction-memory port and buffers fetched words in a small prefetch FIFO.
- It feeds IFinst/IFp4 to the ID stage, honours the ID write-enable IFwip, and redirects on IDwillJump/IDjumpPc.
- Memory wait-states appear to ID as NOP bubbles.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- NOP_INST, 32'h0000_0000, word presented to ID when the buffer is empty.
- BUF_DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  asynchronous active-low reset.
- IFwip  in  1  ID accepts the presented word this cycle (1 = advance, 0 = stall).
- IDwillJump  in  1  redirect request from ID.
- IDjumpPc  in  32  redirect target; bits [1:0] ignored, forced to 00.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word address of request, bits [1:0] = 00.
- imem_ack  in  1  memory completes the request this cycle.
- imem_rdata  in  32  instruction word, valid while imem_ack = 1.
- IFinst  out  32  instruction to ID: buffer head, or NOP_INST when empty.
- IFp4  out  32  PC+4 of the head word; 0 when empty.
- IFvalid  out  1  buffer non-empty (IFinst is a real instruction).

Behaviour:
- Reset (clrn = 0, asynchronous): fpc = RESET_PC; buffer empty with count 0; imem_req = 0; discard flag = 0. Outputs are then IFinst = NOP_INST, IFp4 = 0, IFvalid = 0.
- Reset mid-handshake drops imem_req immediately. The memory must abandon the request; there is no completion.
- Request issue:
  - imem_req rises when no request is outstanding and (count + 0) < BUF_DEPTH.
  - imem_addr = fpc at issue.
  - At most one request is outstanding.
- Handshake:
  - req and addr stay stable until a rising edge where imem_req & imem_ack = 1.
  - ack may be high in the first req cycle (zero wait-state).
  - req deasserts for at least 0 cycles: back-to-back issue is allowed in the cycle after completion if space remains.
- Completion, no discard: push {imem_rdata, fpc_req+4} into the FIFO and set fpc = fpc_req + 4 (32-bit wrap at 32'hFFFF_FFFC -> 0).
- Pop: at an edge with IFwip = 1 and IFvalid = 1, the head is removed. IFwip = 1 while empty changes nothing; ID latches the NOP bubble.
- Push and pop in the same edge: count is unchanged, including when full.
- FIFO: circular read/write pointers with wrap, plus a count 0..BUF_DEPTH. It never overflows because issue is gated on count.
- Redirect: IDwillJump = 1 at an edge, regardless of IFwip.
  - The buffer is flushed (count = 0) and fpc = {IDjumpPc[31:2], 2'b00}.
  - Any push or pop in the same edge is cancelled; redirect has priority.
  - If a request is outstanding and not completing this edge, imem_req stays high with the old address and the discard flag is set. Its data is dropped on ack, fpc is unchanged by that completion, and the flag clears.
  - If the outstanding request completes in the redirect edge, its data is dropped; no flag is needed.
  - The first target-PC request issues in the cycle after the redirect (or after the discard ack).
- Redirect while discard is already set: update fpc only; the flag stays set.
- Latency: with zero-wait memory and an empty buffer, the word at a new fpc appears on IFinst 1 cycle after its request cycle.
- Outputs IFinst, IFp4 and IFvalid are combinational from the FIFO head only, with no path from memory inputs. imem_req and imem_addr are registered.

Test Plan:
- Reset with clrn = 0 -> imem_req = 0, IFinst = 0, IFvalid = 0. After release, imem_req = 1 with imem_addr = 0.
- Zero-wait memory (ack same cycle) returning 32'h11,32'h22,32'h33 at addresses 0,4,8 with IFwip = 1 -> ID sees those words with IFp4 = 4,8,12 on consecutive cycles after the first NOP.
- IFwip = 0 for 5 cycles with zero-wait memory -> buffer fills to 2, imem_req holds 0 with addr 8, and IFinst stays 32'h11. After IFwip returns to 1, the words arrive in order with none lost or duplicated.
- 3-wait-state memory with IFwip = 1 -> IFvalid = 0 and IFinst = NOP_INST for 3 cycles between words; addresses are sequential.
- IDwillJump = 1 with IDjumpPc = 32'h0000_0103 while a request to 0x10 is pending (ack 2 cycles later) -> req stays at 0x10, that data is discarded, the next req is at 0x100, and IFp4 = 0x104.
- Redirect in the same edge as push+pop, and clrn pulsed low mid-handshake -> buffer ends empty at the target, or in full reset state respectively, with imem_req low asynchronously.

Source files
------------

// File: rtl/pipe_fetch_unit.sv
// IF stage: owns the fetch PC, runs a single-outstanding req/ack imem port and a prefetch FIFO.
// Latency: with a zero-wait memory, a word appears on IFinst one cycle after its request cycle.
// Backpressure: IFwip=0 holds the head word; once the FIFO is full, no new request issues.
module pipe_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        IFwip,
    input  logic        IDwillJump,
    input  logic [31:0] IDjumpPc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFinst,
    output logic [31:0] IFp4,
    output logic        IFvalid
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(BUF_DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] p4;
    } entry_t;

    entry_t          fifo_q [BUF_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic [PW:0]     count_nxt;
    logic [31:0]     fpc;
    logic [31:0]     fpc_nxt;
    logic [31:0]     fpc_p4;
    logic            discard;
    logic            ack_hit;
    logic            hold;
    logic            push;
    logic            pop;
    logic            unused_jump_lsb;

    assign unused_jump_lsb = ^IDjumpPc[1:0];

    // imem_addr is held for the whole handshake, so it doubles as the PC of the returning word.
    assign ack_hit = imem_req & imem_ack;
    assign hold    = imem_req & ~imem_ack;
    assign fpc_p4  = imem_addr + 32'd4;
    assign push    = ack_hit & ~discard & ~IDwillJump;
    assign pop     = IFwip & IFvalid & ~IDwillJump;

    always_comb begin
        count_nxt = count;
        if (IDwillJump) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    always_comb begin
        fpc_nxt = fpc;
        if (IDwillJump)
            fpc_nxt = {IDjumpPc[31:2], 2'b00};
        else if (push)
            fpc_nxt = fpc_p4;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fpc       <= {RESET_PC[31:2], 2'b00};
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            imem_req  <= 1'b0;
            imem_addr <= {RESET_PC[31:2], 2'b00};
            discard   <= 1'b0;
        end else begin
            fpc   <= fpc_nxt;
            count <= count_nxt;
            if (IDwillJump) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            // A pending request cannot be withdrawn; a redirect only marks its data as stale.
            if (hold) begin
                discard <= discard | IDwillJump;
            end else begin
                imem_req  <= (count_nxt < DEPTH);
                imem_addr <= fpc_nxt;
                discard   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= '{inst: imem_rdata, p4: fpc_p4};
    end

    assign IFvalid = (count != '0);
    assign IFinst  = IFvalid ? fifo_q[rd_ptr].inst : NOP_INST;
    assign IFp4    = IFvalid ? fifo_q[rd_ptr].p4 : 32'd0;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed bench for pipe_fetch_unit with a small wait-state memory model.
module tb_pipe_fetch_unit;
    logic        clk;
    logic        clrn;
    logic        IFwip;
    logic        IDwillJump;
    logic [31:0] IDjumpPc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IFinst;
    logic [31:0] IFp4;
    logic        IFvalid;

    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    int wcnt;

    pipe_fetch_unit dut (
        .clk        (clk),
        .clrn       (clrn),
        .IFwip      (IFwip),
        .IDwillJump (IDwillJump),
        .IDjumpPc   (IDjumpPc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .IFinst     (IFinst),
        .IFp4       (IFp4),
        .IFvalid    (IFvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks after mem_wait request cycles, data = ((addr>>2)+1)*0x11.
    always @(posedge clk or negedge clrn) begin
        if (!clrn)                     wcnt <= 0;
        else if (imem_req && imem_ack) wcnt <= 0;
        else if (imem_req)             wcnt <= wcnt + 1;
    end
    assign imem_ack   = imem_req && (wcnt >= mem_wait);
    assign imem_rdata = ((imem_addr >> 2) + 32'd1) * 32'h11;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] inst, input logic [31:0] p4);
        chk({tag, "_valid"}, {31'd0, IFvalid}, 32'd1);
        chk({tag, "_inst"}, IFinst, inst);
        chk({tag, "_p4"}, IFp4, p4);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {31'd0, IFvalid}, 32'd0);
        chk({tag, "_inst"}, IFinst, 32'd0);
        chk({tag, "_p4"}, IFp4, 32'd0);
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; IFwip = 1'b0; IDwillJump = 1'b0; IDjumpPc = 32'd0; mem_wait = 0;
        repeat (2) step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk_empty("rst");

        // Zero-wait streaming with ID always accepting.
        clrn = 1'b1; IFwip = 1'b1;
        step();
        chk_req("first", 1'b1, 32'h0);
        chk_empty("first_nop");
        step(); chk_head("zw0", 32'h11, 32'h4); chk_req("zw0", 1'b1, 32'h4);
        step(); chk_head("zw1", 32'h22, 32'h8);
        step(); chk_head("zw2", 32'h33, 32'hC);

        // Stall: FIFO fills to two entries, then drains in order.
        clrn = 1'b0; IFwip = 1'b0;
        step();
        clrn = 1'b1;
        step(); step(); step();
        chk_head("stall_a", 32'h11, 32'h4); chk_req("stall_a", 1'b0, 32'h8);
        step(); step();
        chk_head("stall_b", 32'h11, 32'h4); chk_req("stall_b", 1'b0, 32'h8);
        IFwip = 1'b1;
        step(); chk_head("drain0", 32'h22, 32'h8); chk_req("drain0", 1'b1, 32'h8);
        step(); chk_head("drain1", 32'h33, 32'hC);
        step(); chk_head("drain2", 32'h44, 32'h10); chk_req("drain2", 1'b1, 32'h10);

        // Three wait states: three NOP bubbles between words.
        mem_wait = 3;
        step(); chk_empty("ws_b0"); chk_req("ws_b0", 1'b1, 32'h10);
        step(); chk_empty("ws_b1");
        step(); chk_empty("ws_b2");
        step(); chk_head("ws_w0", 32'h55, 32'h14); chk_req("ws_w0", 1'b1, 32'h14);
        step(); chk_empty("ws_b3");
        step(); step();
        step(); chk_head("ws_w1", 32'h66, 32'h18); chk_req("ws_w1", 1'b1, 32'h18);

        // Redirect while the request to 0x18 is still waiting: its data is discarded.
        IDwillJump = 1'b1; IDjumpPc = 32'h0000_0103;
        step(); chk_empty("jmp_flush"); chk_req("jmp_hold", 1'b1, 32'h18);
        IDwillJump = 1'b0;
        step(); step();
        chk_empty("jmp_wait"); chk_req("jmp_wait", 1'b1, 32'h18);
        step(); chk_empty("jmp_drop"); chk_req("jmp_target", 1'b1, 32'h100);
        mem_wait = 0;
        step(); chk_head("jmp_word", 32'h451, 32'h104); chk_req("jmp_next", 1'b1, 32'h104);

        // Redirect in the same edge as a push and a pop.
        IDwillJump = 1'b1; IDjumpPc = 32'h0000_0200;
        step(); chk_empty("jpp_flush"); chk_req("jpp_target", 1'b1, 32'h200);
        IDwillJump = 1'b0;
        step(); chk_head("jpp_word", 32'h891, 32'h204);

        // Asynchronous reset in the middle of a pending handshake.
        mem_wait = 3;
        step(); chk_empty("arst_pre"); chk_req("arst_pre", 1'b1, 32'h204);
        #2;
        clrn = 1'b0;
        #1;
        chk("arst_req_now", {31'd0, imem_req}, 32'd0);
        chk_empty("arst_now");
        step();
        clrn = 1'b1; mem_wait = 0;
        step(); chk_req("arst_release", 1'b1, 32'h0); chk_empty("arst_release");

        // PC wrap at the top of the address space.
        IDwillJump = 1'b1; IDjumpPc = 32'hFFFF_FFFF; IFwip = 1'b0;
        step(); chk_req("wrap_target", 1'b1, 32'hFFFF_FFFC); chk_empty("wrap_flush");
        IDwillJump = 1'b0;
        step(); chk_head("wrap_word", 32'h4000_0000, 32'h0); chk_req("wrap_next", 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
